// File: rtl/cpu_bus_capture.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_capture
// Description : Front end for the shared-memory block on the CPU's async
//               SRAM-style bus. Synchronises the strobes, glitch-filters
//               writes, queues {addr,data} write commands in a show-ahead
//               FIFO and emits a one-cycle read request per CPU read.
//               Optional statistics counters: define CPU_BUS_CAPTURE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_capture #(
    parameter int AW         = 13,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_LOW    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_ncs,
    input  logic                          i_nwe,
    input  logic                          i_nrd,
    input  logic [AW-1:0]                 i_addr,
    input  logic [DW-1:0]                 i_data_in,
    output logic                          o_wr_valid,
    output logic [AW-1:0]                 o_wr_addr,
    output logic [DW-1:0]                 o_wr_data,
    input  logic                          i_wr_ready,
    output logic                          o_rd_req,
    output logic [AW-1:0]                 o_rd_addr,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow
`ifdef CPU_BUS_CAPTURE_STATS_EN
    ,
    output logic [15:0]                   o_stat_wr,
    output logic [15:0]                   o_stat_rd,
    output logic [15:0]                   o_stat_drop
`endif
);

    localparam int                c_LW      = $clog2(FIFO_DEPTH);
    localparam logic [c_LW:0]     c_DEPTH   = (c_LW+1)'(FIFO_DEPTH);
    localparam logic [3:0]        c_MIN_LOW = 4'(MIN_LOW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser stages; addr/data share the strobe latency so they stay aligned
    // ------------------------------------------------------------------
    logic [1:0]    r_ncs_s, r_nwe_s, r_nrd_s;
    logic [AW-1:0] r_addr_p1, r_addr_p2;
    logic [DW-1:0] r_data_p1, r_data_p2;
    logic [1:0]    r_warm;
    logic          r_armed;

    // Two-flop synchronisers for strobes, matching two-stage pipe for addr/data
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ncs_s   <= 2'b11;
            r_nwe_s   <= 2'b11;
            r_nrd_s   <= 2'b11;
            r_addr_p1 <= '0;
            r_addr_p2 <= '0;
            r_data_p1 <= '0;
            r_data_p2 <= '0;
        end else begin
            r_ncs_s   <= {r_ncs_s[0], i_ncs};
            r_nwe_s   <= {r_nwe_s[0], i_nwe};
            r_nrd_s   <= {r_nrd_s[0], i_nrd};
            r_addr_p1 <= i_addr;
            r_addr_p2 <= r_addr_p1;
            r_data_p1 <= i_data_in;
            r_data_p2 <= r_data_p1;
        end
    end

    logic w_wr_act, w_rd_act;
    assign w_wr_act = ~r_ncs_s[1] & ~r_nwe_s[1];
    assign w_rd_act = ~r_ncs_s[1] & ~r_nrd_s[1];

    // Arm only after real post-reset samples show the bus idle, so a strobe
    // already low at reset release is never taken as a transaction
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_warm <= {r_warm[0], 1'b1};
            if (r_warm[1] && !w_wr_act && !w_rd_act)
                r_armed <= 1'b1;
        end
    end

    // Count consecutive synchronised write-active cycles, saturating at 15
    logic [3:0] r_low_cnt;
    always_ff @(posedge clk) begin
        if (!reset)
            r_low_cnt <= '0;
        else if (!w_wr_act)
            r_low_cnt <= '0;
        else if (r_low_cnt != 4'hF)
            r_low_cnt <= r_low_cnt + 4'd1;
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t r_state, w_state_nxt;
    logic   w_latch, w_push, w_rd_start;

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control strobes; writes win over reads
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_push      = 1'b0;
        w_rd_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed) begin
                    if (w_wr_act) begin
                        w_state_nxt = ST_WRITE;
                        w_latch     = 1'b1;
                    end else if (w_rd_act) begin
                        w_state_nxt = ST_READ;
                        w_rd_start  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (w_wr_act) begin
                    w_latch = 1'b1;
                end else begin
                    w_push      = (r_low_cnt >= c_MIN_LOW);
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!w_rd_act)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the latest address/data seen while the write strobe is active
    logic [AW-1:0] r_cap_addr;
    logic [DW-1:0] r_cap_data;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cap_addr <= '0;
            r_cap_data <= '0;
        end else if (w_latch) begin
            r_cap_addr <= r_addr_p2;
            r_cap_data <= r_data_p2;
        end
    end

    // Read request pulse and held read address
    logic          r_rd_req;
    logic [AW-1:0] r_rd_addr;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_req <= w_rd_start;
            if (w_rd_start)
                r_rd_addr <= r_addr_p2;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead write-command FIFO
    // ------------------------------------------------------------------
    logic [AW+DW-1:0] r_mem [FIFO_DEPTH];
    logic [c_LW-1:0]  r_wptr, r_rptr;
    logic [c_LW:0]    r_count;
    logic             r_overflow;
    logic             w_full, w_pop, w_do_push, w_ovf_drop;

    assign w_full     = (r_count == c_DEPTH);
    assign w_pop      = (r_count != '0) && i_wr_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
    assign w_do_push  = w_push && (!w_full || w_pop);
    assign w_ovf_drop = w_push && w_full && !w_pop;

    // Storage array, no reset needed; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= {r_cap_addr, r_cap_data};
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_drop)
                r_overflow <= 1'b1;
        end
    end

    assign o_wr_valid   = (r_count != '0);
    assign o_wr_addr    = r_mem[r_rptr][AW+DW-1:DW];
    assign o_wr_data    = r_mem[r_rptr][DW-1:0];
    assign o_rd_req     = r_rd_req;
    assign o_rd_addr    = r_rd_addr;
    assign o_fifo_level = r_count;
    assign o_overflow   = r_overflow;

`ifdef CPU_BUS_CAPTURE_STATS_EN
    logic        w_glitch;
    logic [15:0] r_stat_wr, r_stat_rd, r_stat_drop;

    assign w_glitch = (r_state == ST_WRITE) && !w_wr_act && (r_low_cnt < c_MIN_LOW);

    // Free-running event counters, wrap modulo 2^16
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_wr   <= '0;
            r_stat_rd   <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_do_push)
                r_stat_wr <= r_stat_wr + 16'd1;
            if (w_rd_start)
                r_stat_rd <= r_stat_rd + 16'd1;
            if (w_glitch || w_ovf_drop)
                r_stat_drop <= r_stat_drop + 16'd1;
        end
    end

    assign o_stat_wr   = r_stat_wr;
    assign o_stat_rd   = r_stat_rd;
    assign o_stat_drop = r_stat_drop;
`endif

endmodule
`default_nettype wire
